// File: rtl/ghash_ctrl.sv
// GHASH sequencer: drives one shared gfm multiplier to compute Y_i = (Y_{i-1} ^ X_i) * H over a block stream.
// Owns the hash key, the running accumulator, the gfm start handshake and a hang watchdog.
module ghash_ctrl #(
  parameter int unsigned GFM_BITS    = 128,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                h_load,
  input  logic [GFM_BITS-1:0] h_key,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [GFM_BITS-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [GFM_BITS-1:0] out_data,
  output logic                gfm_en,
  output logic [GFM_BITS-1:0] gfm_a,
  output logic [GFM_BITS-1:0] gfm_b,
  input  logic [GFM_BITS-1:0] gfm_result,
  input  logic                gfm_done,
  output logic                busy,
  output logic                error
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC + 1);
  // Last WAIT cycle in which done is still accepted; the error flag then lands
  // exactly TIMEOUT_CYC edges after gfm_en rose.
  localparam int unsigned LAST_WAIT = TIMEOUT_CYC - 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_OUTPUT = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [GFM_BITS-1:0] h_q;
  logic [GFM_BITS-1:0] y_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;

  logic key_ld, blk_ld, res_ld, out_ld, y_clr, cnt_clr, cnt_inc, wd_trip;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d = state_q;
    key_ld  = 1'b0;
    blk_ld  = 1'b0;
    res_ld  = 1'b0;
    out_ld  = 1'b0;
    y_clr   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    wd_trip = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A key load takes priority; a pending block is picked up next cycle.
        if (h_load) begin
          key_ld = 1'b1;
        end else if (in_valid) begin
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          blk_ld  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gfm_done) begin
          res_ld = 1'b1;
          if (last_q) begin
            out_ld  = 1'b1;
            state_d = S_OUTPUT;
          end else begin
            state_d = S_ACCEPT;
          end
        end else if (cnt_q == CNT_W'(LAST_WAIT)) begin
          wd_trip = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          y_clr   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      gfm_en    <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      in_ready  <= (state_d == S_ACCEPT);
      out_valid <= (state_d == S_OUTPUT);
      gfm_en    <= (state_d == S_START);
      busy      <= (state_d != S_IDLE);
      error     <= error | wd_trip;
    end
  end

  // Key, accumulator, operands and result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q      <= '0;
      y_q      <= '0;
      last_q   <= 1'b0;
      gfm_a    <= '0;
      gfm_b    <= '0;
      out_data <= '0;
    end else begin
      if (key_ld) begin
        h_q <= h_key;
      end
      if (blk_ld) begin
        gfm_a  <= y_q ^ in_data;
        gfm_b  <= h_q;
        last_q <= in_last;
      end
      if (y_clr) begin
        y_q <= '0;
      end else if (res_ld) begin
        y_q <= gfm_result;
      end
      if (out_ld) begin
        out_data <= gfm_result;
      end
    end
  end

  // Watchdog counter for the gfm handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
